// File: rtl/quantiumv_pkg.sv
// Shared decode definitions for the QuantiumV front end: RV32I opcodes,
// instruction format enum, decoded-bundle layout and buffer states.
package quantiumv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6
    } fmt_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        fmt_t        fmt;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } decode_bundle_t;

    // Unknown opcodes fall into SYS so their immediate reads as zero.
    function automatic fmt_t opcode_fmt(input logic [6:0] opc);
        fmt_t f;
        case (opc)
            OPC_LUI, OPC_AUIPC:             f = FMT_U;
            OPC_JAL:                        f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: f = FMT_I;
            OPC_STORE:                      f = FMT_S;
            OPC_BRANCH:                     f = FMT_B;
            OPC_OP:                         f = FMT_R;
            default:                        f = FMT_SYS;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode->execute handshake bundle; slave is the decode stage's view,
// master is the surrounding pipeline's view.
interface decode_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [2:0]  out_fmt;
    logic        out_uses_rs1;
    logic        out_uses_rs2;
    logic        out_writes_rd;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_ins, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_funct3, out_funct7, out_fmt, out_uses_rs1, out_uses_rs2,
               out_writes_rd, out_illegal
    );

    modport master (
        output in_valid, in_ins, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_funct3, out_funct7, out_fmt, out_uses_rs1, out_uses_rs2,
               out_writes_rd, out_illegal
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// RV32I immediate extraction: combinational, sign-extended from ins[31],
// zero for R and SYS formats.
module imm_gen
    import quantiumv_pkg::*;
(
    input  logic [31:0] ins_i,
    input  fmt_t        fmt_i,
    output logic [31:0] imm_o
);

    // The opcode bits carry no immediate information.
    logic unused_opc;
    assign unused_opc = ^ins_i[6:0];

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            FMT_I:   imm_o = {{20{ins_i[31]}}, ins_i[31:20]};
            FMT_S:   imm_o = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
            FMT_B:   imm_o = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
            FMT_U:   imm_o = {ins_i[31:12], 12'b0};
            FMT_J:   imm_o = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// QuantiumV decode stage: RV32I decode into a one-entry registered bundle with
// valid/ready on both sides and flush. Define QUANTIUMV_DECODE_RVM_EN to accept RV32M.
module decode_stage
    import quantiumv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit ZERO_ILLEGAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    logic [6:0]     opc;
    logic [2:0]     f3;
    logic [6:0]     f7;
    fmt_t           fmt_w;
    logic [XLEN-1:0] imm_w;
    logic           op_legal;
    logic           legal;
    logic           rs1_use;
    logic           rs2_use;
    logic           rd_write;
    logic           in_fire;
    decode_bundle_t dec_d;
    decode_bundle_t bundle_q;
    buf_state_t     state_q;

    assign opc   = bus.in_ins[6:0];
    assign f3    = bus.in_ins[14:12];
    assign f7    = bus.in_ins[31:25];
    assign fmt_w = opcode_fmt(opc);

    imm_gen u_imm_gen (
        .ins_i (bus.in_ins),
        .fmt_i (fmt_w),
        .imm_o (imm_w)
    );

    always_comb begin
        op_legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
`ifdef QUANTIUMV_DECODE_RVM_EN
        if (f7 == 7'b0000001) begin
            op_legal = 1'b1;
        end
`endif
    end

    // SYS (FENCE/ECALL/CSR) is passed through without operand or writeback flags.
    always_comb begin
        legal    = 1'b1;
        rs1_use  = 1'b0;
        rs2_use  = 1'b0;
        rd_write = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: rd_write = 1'b1;
            OPC_JALR: begin
                rs1_use  = 1'b1;
                rd_write = 1'b1;
                legal    = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_LOAD: begin
                rs1_use  = 1'b1;
                rd_write = 1'b1;
                legal    = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                legal   = (f3 <= 3'b010);
            end
            OPC_OP_IMM: begin
                rs1_use  = 1'b1;
                rd_write = 1'b1;
                if (f3 == 3'b001) begin
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                end
            end
            OPC_OP: begin
                rs1_use  = 1'b1;
                rs2_use  = 1'b1;
                rd_write = 1'b1;
                legal    = op_legal;
            end
            OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        if (ZERO_ILLEGAL && (bus.in_ins == 32'd0)) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        dec_d           = '0;
        dec_d.pc        = bus.in_pc;
        dec_d.rd        = bus.in_ins[11:7];
        dec_d.rs1       = bus.in_ins[19:15];
        dec_d.rs2       = bus.in_ins[24:20];
        dec_d.imm       = imm_w;
        dec_d.funct3    = f3;
        dec_d.funct7    = f7;
        dec_d.fmt       = fmt_w;
        dec_d.uses_rs1  = legal && rs1_use;
        dec_d.uses_rs2  = legal && rs2_use;
        dec_d.writes_rd = legal && rd_write && (bus.in_ins[11:7] != 5'd0);
        dec_d.illegal   = !legal;
    end

    assign bus.in_ready = ((state_q == BUF_EMPTY) || bus.out_ready) && !bus.flush;
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Flush wins; otherwise a new input refills (or keeps) the buffer and a bare
    // out_ready drains it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BUF_EMPTY;
            bundle_q <= '0;
        end else if (bus.flush) begin
            state_q <= BUF_EMPTY;
        end else if (in_fire) begin
            state_q  <= BUF_FULL;
            bundle_q <= dec_d;
        end else if (bus.out_ready) begin
            state_q <= BUF_EMPTY;
        end
    end

    assign bus.out_valid     = (state_q == BUF_FULL);
    assign bus.out_pc        = bundle_q.pc;
    assign bus.out_rd        = bundle_q.rd;
    assign bus.out_rs1       = bundle_q.rs1;
    assign bus.out_rs2       = bundle_q.rs2;
    assign bus.out_imm       = bundle_q.imm;
    assign bus.out_funct3    = bundle_q.funct3;
    assign bus.out_funct7    = bundle_q.funct7;
    assign bus.out_fmt       = bundle_q.fmt;
    assign bus.out_uses_rs1  = bundle_q.uses_rs1;
    assign bus.out_uses_rs2  = bundle_q.uses_rs2;
    assign bus.out_writes_rd = bundle_q.writes_rd;
    assign bus.out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed test-plan words plus randomized
// traffic, checked against an arithmetic RV32I reference model.
module tb_decode_stage;
    import quantiumv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if dif ();

    decode_stage #(
        .XLEN         (32),
        .ZERO_ILLEGAL (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  fmt;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   model_full = 1'b0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endfunction

    // Reference decode: immediates built as signed integer sums of the fields.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t       e;
        bit         legal;
        int         v;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.f3 = f3; e.f7 = f7;
        legal = 1'b1;
        case (w[6:0])
            OPC_LUI, OPC_AUIPC: begin e.fmt = FMT_U; e.wr = 1; end
            OPC_JAL:    begin e.fmt = FMT_J; e.wr = 1; end
            OPC_JALR:   begin e.fmt = FMT_I; e.u1 = 1; e.wr = 1; legal = (f3 == 0); end
            OPC_BRANCH: begin e.fmt = FMT_B; e.u1 = 1; e.u2 = 1; legal = !(f3 == 2 || f3 == 3); end
            OPC_LOAD:   begin e.fmt = FMT_I; e.u1 = 1; e.wr = 1; legal = !(f3 == 3 || f3 == 6 || f3 == 7); end
            OPC_STORE:  begin e.fmt = FMT_S; e.u1 = 1; e.u2 = 1; legal = (f3 < 3); end
            OPC_OP_IMM: begin
                e.fmt = FMT_I; e.u1 = 1; e.wr = 1;
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) legal = (f7 == 0 || f7 == 32);
            end
            OPC_OP: begin
                e.fmt = FMT_R; e.u1 = 1; e.u2 = 1; e.wr = 1;
                legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
`ifdef QUANTIUMV_DECODE_RVM_EN
                if (f7 == 1) legal = 1'b1;
`endif
            end
            OPC_MISC_MEM, OPC_SYSTEM: e.fmt = FMT_SYS;
            default: begin e.fmt = FMT_SYS; legal = 1'b0; end
        endcase
        if (w == 32'd0) legal = 1'b0;
        case (e.fmt)
            FMT_I: v = int'(w[30:20]) - (w[31] ? 2048 : 0);
            FMT_S: v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
            FMT_B: v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
            FMT_U: v = int'(w & 32'hFFFFF000);
            FMT_J: v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
            default: v = 0;
        endcase
        e.imm = v;
        if (!legal) begin e.u1 = 0; e.u2 = 0; e.wr = 0; end
        if (e.rd == 0) e.wr = 0;
        e.ill = !legal;
        return e;
    endfunction

    function automatic exp_t sample_out();
        exp_t a;
        a.pc = dif.out_pc; a.rd = dif.out_rd; a.rs1 = dif.out_rs1; a.rs2 = dif.out_rs2;
        a.imm = dif.out_imm; a.f3 = dif.out_funct3; a.f7 = dif.out_funct7; a.fmt = dif.out_fmt;
        a.u1 = dif.out_uses_rs1; a.u2 = dif.out_uses_rs2; a.wr = dif.out_writes_rd; a.ill = dif.out_illegal;
        return a;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 13);
        case (k)
            0: w[6:0] = OPC_LUI;    1: w[6:0] = OPC_AUIPC;  2: w[6:0] = OPC_JAL;
            3: w[6:0] = OPC_JALR;   4: w[6:0] = OPC_BRANCH; 5: w[6:0] = OPC_LOAD;
            6: w[6:0] = OPC_STORE;  7: w[6:0] = OPC_OP_IMM; 8: w[6:0] = OPC_OP;
            9: w[6:0] = OPC_MISC_MEM; 10: w[6:0] = OPC_SYSTEM;
            11: w = w;
            12: w = 32'd0;
            default: w[6:0] = OPC_OP;
        endcase
        if (w[6:0] == OPC_OP || w[6:0] == OPC_OP_IMM) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'b0000000;
                1: w[31:25] = 7'b0100000;
                2: w[31:25] = 7'b0000001;
                default: w[31:25] = w[31:25];
            endcase
        end
        if (w[6:0] == OPC_JALR && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
        return w;
    endfunction

    // Monitor: every cycle the buffer is full it must show the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && dif.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL bundle: got out_valid=1 expected no pending instruction");
                end else begin
                    check("bundle", sample_out(), exp_q[0]);
                    if (dif.out_ready) begin
                        $display("xfer pc=%h imm=%h fmt=%0d ill=%0d", exp_q[0].pc, exp_q[0].imm, exp_q[0].fmt, exp_q[0].ill);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One cycle of stimulus, applied at posedge+1 and returning at the next posedge+1.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input bit fl, output bit acc);
        dif.in_valid  = v;
        dif.in_ins    = ins;
        dif.in_pc     = pc;
        dif.out_ready = ordy;
        dif.flush     = fl;
        @(negedge clk);
        check("in_ready", dif.in_ready, (!model_full || ordy) && !fl);
        check("out_valid", dif.out_valid, model_full);
        acc = v && dif.in_ready;
        #1;
        if (fl) begin
            if (model_full && !ordy && exp_q.size() > 0) void'(exp_q.pop_front());
            model_full = 1'b0;
        end else begin
            model_full = acc || (model_full && !ordy);
            if (acc) exp_q.push_back(ref_decode(ins, pc));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] ins;
        bit          acc;
        bit          v;
        bit          fl;
        bit          ordy;

        dif.in_valid = 0; dif.in_ins = '0; dif.in_pc = '0; dif.out_ready = 0; dif.flush = 0;
        #2 rst = 1'b0;
        #2;
        check("reset_valid", dif.out_valid, 1'b0);
        check("reset_bundle", sample_out(), '0);
        @(posedge clk);
        #1 rst = 1'b1;

        pc = 32'h0000_1000;
        step(1, 32'h00500093, pc, 1, 0, acc); pc += 4;   // ADDI x1,x0,5
        step(1, 32'h123452B7, pc, 1, 0, acc); pc += 4;   // LUI x5,0x12345
        step(1, 32'hFE000EE3, pc, 1, 0, acc); pc += 4;   // BEQ x0,x0,-4
        step(1, 32'h022081B3, pc, 1, 0, acc); pc += 4;   // MUL x3,x1,x2
        step(1, 32'h00000000, pc, 1, 0, acc); pc += 4;   // zero word
        step(0, 32'h0, pc, 1, 0, acc);

        // Backpressure: one held, three stalled cycles, then four back-to-back.
        step(1, 32'h00100113, pc, 0, 0, acc); pc += 4;
        for (int i = 0; i < 3; i++) step(1, 32'h00200193, pc, 0, 0, acc);
        step(1, 32'h00200193, pc, 1, 0, acc); pc += 4;
        step(1, 32'h00300213, pc, 1, 0, acc); pc += 4;
        step(1, 32'h00400293, pc, 1, 0, acc); pc += 4;
        step(0, 32'h0, pc, 1, 0, acc);

        // Flush while full with a pending input.
        step(1, 32'h00700393, pc, 0, 0, acc); pc += 4;
        step(1, 32'h00800413, pc, 0, 1, acc);
        step(0, 32'h0, pc, 1, 0, acc);
        step(0, 32'h0, pc, 0, 1, acc);

        // Asynchronous reset mid-stream.
        step(1, 32'hFFF00513, pc, 0, 0, acc); pc += 4;
        step(1, 32'h00B50593, pc, 0, 0, acc);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", dif.out_valid, 1'b0);
        check("async_rst_bundle", sample_out(), '0);
        exp_q.delete();
        model_full = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        ins = rand_ins();
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
            step(v, ins, pc, ordy, fl, acc);
            if (acc) begin
                pc += 4;
                ins = rand_ins();
            end
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(0, 32'h0, pc, 1, 0, acc);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage 2 of the QuantiumV core; sits directly downstream of fetch_stage and consumes its instruction word plus PC.
- Decodes RV32I into a registered bundle: register indices, immediate, format, control flags and an illegal flag.
- Handshakes valid/ready on both sides and supports a pipeline flush from the branch/exception logic.
- One-entry output register; latency of 1 cycle.

Parameters:
- XLEN, 32, datapath and immediate width; only 32 is supported.
- ZERO_ILLEGAL, 1, when 1 the all-zero word 0x00000000 decodes as illegal.

Ports:
- clk  input  1  core clock; all state is updated on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  fetch presents in_ins/in_pc.
- in_ready  output  1  decode accepts this cycle.
- in_ins  input  32  instruction word (fetch INS).
- in_pc  input  32  PC of in_ins.
- flush  input  1  discard held and incoming instruction.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- out_pc  output  32  PC of the decoded instruction.
- out_rd, out_rs1, out_rs2  output  5 each  register indices.
- out_imm  output  32  sign-extended immediate.
- out_funct3  output  3  funct3 field.
- out_funct7  output  7  funct7 field.
- out_fmt  output  3  format enum: R, I, S, B, U, J, SYS.
- out_uses_rs1, out_uses_rs2  output  1 each  operand-read flags.
- out_writes_rd  output  1  register writeback flag; forced to 0 when rd==0.
- out_illegal  output  1  illegal-instruction flag.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0 and every bundle output=0, with no dependence on clk.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational); it is also forced to 0 while flush=1.
  - A transfer happens when in_valid && in_ready. The bundle is registered and out_valid=1 on the next edge.
  - out_valid stays 1 and the bundle stays stable until out_ready=1.
  - Output buffer states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on input transfer. FULL→EMPTY on out_ready without a new input. FULL→FULL on simultaneous out_ready and input transfer, which gives full throughput of 1 instruction per cycle.
- Flush has priority over everything else: the next state is EMPTY and the input is not accepted that cycle. A flush while EMPTY is a no-op.
- Immediates, sign-extended from bit 31:
  - I: ins[31:20]
  - S: {ins[31:25], ins[11:7]}
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}
  - U: {ins[31:12], 12'b0}
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}
  - R and SYS: 0
- Opcode map:
  - LUI, AUIPC → U
  - JAL → J
  - JALR, LOAD, OP-IMM → I
  - STORE → S
  - BRANCH → B
  - OP → R
  - MISC-MEM, SYSTEM → SYS
- Illegal conditions:
  - ins[1:0] != 2'b11
  - unknown opcode
  - BRANCH with funct3 of 010 or 011
  - LOAD with funct3 of 011, 110 or 111
  - STORE with funct3 > 010
  - JALR with funct3 != 0
  - OP-IMM shifts with a bad funct7
  - OP with funct7 outside {0000000, 0100000}, or funct7 0100000 with funct3 other than 000 or 101
  - zero word when ZERO_ILLEGAL=1
- Illegal words still flow through with out_illegal=1 and out_writes_rd=0, uses_rs1=0, uses_rs2=0.

Optional Feature:
- QUANTIUMV_DECODE_RVM_EN defined: OP with funct7=0000001 (MUL through REMU, all funct3 values) is legal, format R, uses_rs1=uses_rs2=1, writes_rd set per rd.
- Undefined: funct7=0000001 on OP is illegal.

Decomposition:
- Package quantiumv_pkg holds:
  - the opcode localparams
  - the fmt_t enum
  - the decoded-bundle struct decode_bundle_t
- Sub-module imm_gen: purely combinational, takes ins and fmt, returns imm.
- decode_stage holds the output register and the handshake logic.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready=1 → next cycle: out_valid=1, rd=1, rs1=0, imm=5, fmt=I, writes_rd=1, illegal=0.
- LUI x5,0x12345 (0x123452B7) → rd=5, imm=0x12345000, fmt=U, uses_rs1=0.
- BEQ x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, fmt=B, writes_rd=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and the bundle is stable. Release → stream of 4 instructions at 1 per cycle in order.
- Flush while FULL with in_valid=1 → next cycle out_valid=0 and the input is not accepted. Reset asserted mid-stream → out_valid=0 immediately, without a clock edge.
- MUL x3,x1,x2 (0x022081B3) → illegal=1 without QUANTIUMV_DECODE_RVM_EN; with it, illegal=0, rd=3, fmt=R. Word 0x00000000 → illegal=1.
